wb_cmd_master: RTL and testbench

- Single-outstanding Wishbone B3 classic initiator inside the user project.
- Converts a valid/ready command channel into single read/write bus cycles toward user-area Wishbone slaves (e.g. test_mixer register files).
- Returns read data and completion status on a valid/ready response channel.
- Bounded wait: cycle times out if no slave acknowledges.

---
 rtl/wb_cmd_master.sv | 172 +++++++++++++++++
 tb/tb_wb_cmd_master.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-outstanding Wishbone B3 classic initiator.
// Takes one command at a time from a valid/ready channel, runs one bus
// cycle (with an optional watchdog on STB), and returns read data plus a
// completion status on a valid/ready response channel.
module wb_cmd_master #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ERRCNT_W       = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [31:0]         cmd_adr_i,
  input  logic [31:0]         cmd_dat_i,
  input  logic [3:0]          cmd_sel_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_dat_o,
  output logic [1:0]          rsp_status_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [3:0]          wbm_sel_o,
  output logic [31:0]         wbm_adr_o,
  output logic [31:0]         wbm_dat_o,
  input  logic [31:0]         wbm_dat_i,
  input  logic                wbm_ack_i,
  input  logic                wbm_err_i,
  output logic                busy_o,
  output logic [ERRCNT_W-1:0] err_count_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BUS_ERR = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  // The timer counts completed STB-high cycles; abort when the last allowed
  // cycle ends unanswered.
  localparam bit          TO_EN     = (TIMEOUT_CYCLES != 0);
  localparam int          TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [15:0] TO_LAST   = TO_LAST_I[15:0];

  logic [1:0]          state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [31:0]         adr_q, adr_d;
  logic [31:0]         dat_q, dat_d;
  logic [3:0]          sel_q, sel_d;
  logic [15:0]         timer_q, timer_d;
  logic [31:0]         rsp_dat_q, rsp_dat_d;
  logic [1:0]          rsp_status_q, rsp_status_d;
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;
  logic                err_inc;

  // Next-state, bus-cycle and response computation.
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    timer_d      = timer_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    err_inc      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_ready_q && cmd_valid_i) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          cyc_d   = 1'b1;
          timer_d = 16'd0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        // err wins over ack when a slave raises both.
        if (wbm_err_i) begin
          rsp_dat_d    = 32'h0;
          rsp_status_d = ST_BUS_ERR;
          err_inc      = 1'b1;
          cyc_d        = 1'b0;
          state_d      = S_RESP;
        end else if (wbm_ack_i) begin
          rsp_dat_d    = we_q ? 32'h0 : wbm_dat_i;
          rsp_status_d = ST_OK;
          cyc_d        = 1'b0;
          state_d      = S_RESP;
        end else if (TO_EN && (timer_q == TO_LAST)) begin
          rsp_dat_d    = 32'h0;
          rsp_status_d = ST_TIMEOUT;
          err_inc      = 1'b1;
          cyc_d        = 1'b0;
          state_d      = S_RESP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
      end
    endcase

    // Registered ready: low during reset, and only high once back in IDLE,
    // so a new command can never be taken on the response handshake edge.
    cmd_ready_d = (state_d == S_IDLE);

    err_count_d = err_count_q;
    if (err_inc && (err_count_q != {ERRCNT_W{1'b1}})) begin
      err_count_d = err_count_q + ERRCNT_W'(1);
    end
  end

  // State and datapath registers; async reset drops CYC/STB at once.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= 32'h0;
      dat_q        <= 32'h0;
      sel_q        <= 4'h0;
      timer_q      <= 16'd0;
      rsp_dat_q    <= 32'h0;
      rsp_status_q <= 2'b00;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      timer_q      <= timer_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
      err_count_q  <= err_count_d;
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = (state_q == S_RESP);
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;
  assign wbm_cyc_o    = cyc_q;
  assign wbm_stb_o    = cyc_q;
  assign wbm_we_o     = we_q;
  assign wbm_sel_o    = sel_q;
  assign wbm_adr_o    = adr_q;
  assign wbm_dat_o    = dat_q;
  assign busy_o       = (state_q != S_IDLE);
  assign err_count_o  = err_count_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Testbench for wb_cmd_master: directed scenarios plus randomized
// transactions checked against a transaction-level expectation model.
module tb_wb_cmd_master;

  localparam int TO     = 8;
  localparam int EW     = 3;
  localparam int ERRMAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_we_i = 1'b0;
  logic [31:0]   cmd_adr_i = 32'h0;
  logic [31:0]   cmd_dat_i = 32'h0;
  logic [3:0]    cmd_sel_i = 4'h0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [31:0]   rsp_dat_o;
  logic [1:0]    rsp_status_o;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]    wbm_sel_o;
  logic [31:0]   wbm_adr_o, wbm_dat_o;
  logic [31:0]   wbm_dat_i = 32'h0;
  logic          wbm_ack_i = 1'b0;
  logic          wbm_err_i = 1'b0;
  logic          busy_o;
  logic [EW-1:0] err_count_o;

  int n_vec = 0;
  int n_bad = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  wb_cmd_master #(.TIMEOUT_CYCLES(TO), .ERRCNT_W(EW)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_status_o(rsp_status_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .busy_o(busy_o), .err_count_o(err_count_o)
  );

  // One complete transaction. kind: 0 ack, 1 err, 2 ack+err, 3 silent slave.
  // The slave answers in STB cycle waits+1. pend keeps a further command
  // waiting while the response is held back for 'hold' cycles.
  task automatic do_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int kind, input int waits,
                        input logic [31:0] rdata, input int hold, input bit pend);
    int          exp_stb;
    int          stb_cnt;
    int          guard;
    logic [1:0]  exp_st;
    logic [31:0] exp_dat;
    // Expected outcome from the slave behaviour and the timeout window.
    if (kind == 3 || waits + 1 > TO) begin
      exp_stb = TO;
      exp_st  = 2'b10;
    end else begin
      exp_stb = waits + 1;
      exp_st  = (kind == 0) ? 2'b00 : 2'b01;
    end
    exp_dat = (exp_st == 2'b00 && !we) ? rdata : 32'h0;
    if (exp_st != 2'b00 && exp_err < ERRMAX) exp_err++;

    cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel; cmd_valid_i = 1'b1;
    guard = 0;
    while (cmd_ready_o !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    n_vec++;
    if (cmd_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL accept_wait: cmd_ready=%b required 1", cmd_ready_o);
    end
    @(posedge clk); #1;
    // Scramble the command inputs so any leak into the held bus values shows.
    cmd_valid_i = 1'b0; cmd_we_i = ~we; cmd_adr_i = $urandom; cmd_dat_i = $urandom;
    cmd_sel_i = 4'($urandom);

    stb_cnt = 0;
    while (wbm_stb_o === 1'b1 && stb_cnt < 64) begin
      stb_cnt++;
      n_vec++;
      if ({wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, cmd_ready_o, rsp_valid_o, busy_o}
          !== {1'b1, we, adr, dat, sel, 1'b0, 1'b0, 1'b1}) begin
        n_bad++;
        $display("FAIL bus_hold: cyc/we/adr/dat/sel/rdy/rv/busy=%b/%b/%h/%h/%h/%b/%b/%b required 1/%b/%h/%h/%h/0/0/1",
                 wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, cmd_ready_o, rsp_valid_o, busy_o,
                 we, adr, dat, sel);
      end
      wbm_dat_i = $urandom;
      if (kind != 3 && stb_cnt == waits + 1) begin
        wbm_ack_i = (kind != 1);
        wbm_err_i = (kind != 0);
        wbm_dat_i = rdata;
      end
      @(posedge clk); #1;
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    end

    n_vec++;
    if (stb_cnt != exp_stb) begin
      n_bad++;
      $display("FAIL stb_cycles: got %0d required %0d", stb_cnt, exp_stb);
    end
    n_vec++;
    if ({rsp_valid_o, wbm_cyc_o, wbm_stb_o, busy_o, cmd_ready_o} !== 5'b10010) begin
      n_bad++;
      $display("FAIL resp_entry: rv/cyc/stb/busy/rdy=%b%b%b%b%b required 10010",
               rsp_valid_o, wbm_cyc_o, wbm_stb_o, busy_o, cmd_ready_o);
    end
    n_vec++;
    if ({rsp_dat_o, rsp_status_o} !== {exp_dat, exp_st}) begin
      n_bad++;
      $display("FAIL rsp_data: dat=%h st=%b required dat=%h st=%b", rsp_dat_o, rsp_status_o, exp_dat, exp_st);
    end
    n_vec++;
    if (err_count_o !== EW'(exp_err)) begin
      n_bad++;
      $display("FAIL err_count: got %0d required %0d", err_count_o, exp_err);
    end
    n_vec++;
    if ({wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o} !== {we, adr, dat, sel}) begin
      n_bad++;
      $display("FAIL bus_retain: we/adr/dat/sel=%b/%h/%h/%h required %b/%h/%h/%h",
               wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, we, adr, dat, sel);
    end

    // Response held back; stray ack/err must be ignored here.
    for (int i = 0; i < hold; i++) begin
      cmd_valid_i = pend;
      wbm_ack_i = 1'($urandom); wbm_err_i = 1'($urandom);
      @(posedge clk); #1;
      n_vec++;
      if ({rsp_valid_o, rsp_dat_o, rsp_status_o, cmd_ready_o, wbm_cyc_o} !== {1'b1, exp_dat, exp_st, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL rsp_stall: rv/dat/st/rdy/cyc=%b/%h/%b/%b/%b required 1/%h/%b/0/0",
                 rsp_valid_o, rsp_dat_o, rsp_status_o, cmd_ready_o, wbm_cyc_o, exp_dat, exp_st);
      end
    end
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    cmd_valid_i = pend;
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    n_vec++;
    if ({rsp_valid_o, busy_o, cmd_ready_o, wbm_cyc_o, err_count_o} !== {4'b0010, EW'(exp_err)}) begin
      n_bad++;
      $display("FAIL rsp_done: rv/busy/rdy/cyc/errcnt=%b/%b/%b/%b/%0d required 0/0/1/0/%0d",
               rsp_valid_o, busy_o, cmd_ready_o, wbm_cyc_o, err_count_o, exp_err);
    end
    $display("txn we=%0d adr=%h kind=%0d waits=%0d stb=%0d status=%b rdat=%h errcnt=%0d",
             we, adr, kind, waits, stb_cnt, rsp_status_o, rsp_dat_o, err_count_o);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
         wbm_sel_o, wbm_adr_o, wbm_dat_o, busy_o, err_count_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b rv=%b cyc=%b stb=%b adr=%h busy=%b errcnt=%0d required all 0",
               cmd_ready_o, rsp_valid_o, wbm_cyc_o, wbm_stb_o, wbm_adr_o, busy_o, err_count_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({cmd_ready_o, busy_o, wbm_cyc_o} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_release: rdy/busy/cyc=%b%b%b required 100", cmd_ready_o, busy_o, wbm_cyc_o);
    end
    exp_err = 0;
  endtask

  task automatic test_zero_wait_write();
    do_txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0, 0, 1'b0);
  endtask

  task automatic test_read_wait();
    do_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 0, 3, 32'h1234_5678, 1, 1'b0);
  endtask

  task automatic test_timeout();
    do_txn(1'b0, 32'h3000_0020, 32'h0, 4'h3, 3, 0, 32'h0, 0, 1'b0);
    do_txn(1'b0, 32'h3000_0024, 32'h0, 4'hC, 0, TO - 1, 32'hA5A5_0001, 0, 1'b0);
    do_txn(1'b1, 32'h3000_0028, 32'h55, 4'h1, 1, TO - 1, 32'h0, 0, 1'b0);
  endtask

  task automatic test_both();
    do_txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, 2, 1, 32'hFFFF_FFFF, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_txn(1'b0, 32'h3000_0040, 32'h0, 4'hF, 0, 0, 32'hCAFE_0040, 5, 1'b1);
    do_txn(1'b1, 32'h3000_0044, 32'h0BAD_F00D, 4'h6, 0, 2, 32'h0, 0, 1'b0);
  endtask

  task automatic test_err_saturation();
    for (int i = 0; i < ERRMAX + 2; i++) begin
      do_txn(1'b1, 32'h3000_0100 + 32'(i * 4), $urandom, 4'hF, 1, i % 3, 32'h0, 0, 1'b0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_txn(1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 10)), $urandom, int'($urandom_range(0, 3)), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    cmd_we_i = 1'b0; cmd_adr_i = 32'h3000_0200; cmd_sel_i = 4'hF; cmd_valid_i = 1'b1;
    guard = 0;
    while (cmd_ready_o !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (wbm_stb_o !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_stb2: stb=%b required 1", wbm_stb_o);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({wbm_cyc_o, wbm_stb_o, rsp_valid_o, busy_o, cmd_ready_o, err_count_o} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: cyc/stb/rv/busy/rdy=%b%b%b%b%b errcnt=%0d required 00000 0",
               wbm_cyc_o, wbm_stb_o, rsp_valid_o, busy_o, cmd_ready_o, err_count_o);
    end
    exp_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_txn(1'b1, 32'h3000_0204, 32'h1357_9BDF, 4'hF, 0, 2, 32'h0, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_read_wait();
    test_timeout();
    test_both();
    test_back_to_back();
    test_err_saturation();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
